// File: rtl/fetch_queue.sv
// ============================================================================
// Module   : fetch_queue
// Purpose  : Instruction-fetch front end. It contains the fetch-PC generator,
//            the in-order imem request/response path with several outstanding
//            requests, and a DEPTH-entry prefetch queue toward IF/ID.
// Options  : FQ_PERF_CNT_EN enables the saturating perf_* counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,

    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,

    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,

    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pc4,

    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_flushed,
    output logic [31:0]     perf_stall
);

    localparam int              PTR_W     = $clog2(DEPTH);
    localparam int              CNT_W     = PTR_W + 1;
    localparam logic [CNT_W:0]  OCC_LIMIT = (CNT_W + 1)'(DEPTH);

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [PTR_W-1:0] tag_wr_ptr_q, tag_wr_ptr_d;
    logic [PTR_W-1:0] tag_rd_ptr_q, tag_rd_ptr_d;

    logic [31:0]      instr_mem [DEPTH];
    logic [XLEN-1:0]  pc_mem    [DEPTH];
    logic [XLEN-1:0]  tag_mem   [DEPTH];

    logic [CNT_W:0]   w_occupancy;
    logic             w_req_fire;
    logic             w_rsp_fire;
    logic             w_rsp_keep;
    logic             w_deq_fire;

    // Credit covers both queued entries and requests still owed a slot.
    assign w_occupancy    = {1'b0, inflight_q} + {1'b0, count_q};
    assign imem_req_valid = !rst && (w_occupancy < OCC_LIMIT) && !redirect_valid;
    assign imem_req_addr  = fetch_pc_q;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign w_rsp_fire = imem_rsp_valid && (inflight_q != '0);
    assign w_rsp_keep = w_rsp_fire && (drop_q == '0) && !redirect_valid;
    assign w_deq_fire = out_valid && out_ready && !redirect_valid;

    assign out_valid = (count_q != '0);
    assign out_instr = out_valid ? instr_mem[rd_ptr_q] : '0;
    assign out_pc    = out_valid ? pc_mem[rd_ptr_q]    : '0;
    assign out_pc4   = out_pc + XLEN'(4);

    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        tag_wr_ptr_d = tag_wr_ptr_q;
        tag_rd_ptr_d = tag_rd_ptr_q;
        drop_d       = drop_q;
        inflight_d   = inflight_q + CNT_W'(w_req_fire) - CNT_W'(w_rsp_fire);
        count_d      = count_q + CNT_W'(w_rsp_keep) - CNT_W'(w_deq_fire);

        if (w_req_fire) begin
            fetch_pc_d   = fetch_pc_q + XLEN'(4);
            tag_wr_ptr_d = tag_wr_ptr_q + 1'b1;
        end
        if (w_rsp_fire) begin
            tag_rd_ptr_d = tag_rd_ptr_q + 1'b1;
            if (drop_q != '0) begin
                drop_d = drop_q - 1'b1;
            end
        end
        if (w_rsp_keep) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_deq_fire) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        // Every request still outstanding after this cycle belongs to the
        // squashed stream, so drop is rebuilt rather than accumulated.
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ~XLEN'(3);
            count_d    = '0;
            rd_ptr_d   = wr_ptr_q;
            wr_ptr_d   = wr_ptr_q;
            drop_d     = inflight_q - CNT_W'(w_rsp_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q   <= RESET_PC;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            inflight_q   <= '0;
            drop_q       <= '0;
            tag_wr_ptr_q <= '0;
            tag_rd_ptr_q <= '0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            inflight_q   <= inflight_d;
            drop_q       <= drop_d;
            tag_wr_ptr_q <= tag_wr_ptr_d;
            tag_rd_ptr_q <= tag_rd_ptr_d;
        end
    end

    // Storage arrays need no reset: count_q and out_valid gate their use.
    always_ff @(posedge clk) begin
        if (w_req_fire) begin
            tag_mem[tag_wr_ptr_q] <= fetch_pc_q;
        end
        if (!rst && w_rsp_keep) begin
            instr_mem[wr_ptr_q] <= imem_rsp_data;
            pc_mem[wr_ptr_q]    <= tag_mem[tag_rd_ptr_q];
        end
    end

`ifdef FQ_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_flushed_q, perf_flushed_d;
    logic [31:0] perf_stall_q,   perf_stall_d;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

    // Flushed work = queued entries plus in-flight requests not already doomed.
    always_comb begin
        perf_fetched_d = sat_add(perf_fetched_q, 32'(w_rsp_keep));
        perf_stall_d   = sat_add(perf_stall_q, 32'(out_valid && !out_ready));
        perf_flushed_d = perf_flushed_q;
        if (redirect_valid) begin
            perf_flushed_d = sat_add(perf_flushed_q,
                                     32'(count_q) + 32'(inflight_q - drop_q));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_flushed_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_flushed_q <= perf_flushed_d;
            perf_stall_q   <= perf_stall_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_flushed = perf_flushed_q;
    assign perf_stall   = perf_stall_q;
`else
    assign perf_fetched = '0;
    assign perf_flushed = '0;
    assign perf_stall   = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// ============================================================================
// Module   : tb_fetch_queue
// Purpose  : Randomised self-checking bench for fetch_queue against a
//            queue-based model of the fetch stream and an in-order memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0400;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc4;
    logic [31:0] perf_fetched, perf_flushed, perf_stall;

    fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .out_pc4(out_pc4),
        .perf_fetched(perf_fetched), .perf_flushed(perf_flushed),
        .perf_stall(perf_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        bit          stale;
        int          due;
    } req_t;

    req_t        pend[$];
    logic [31:0] q[$];
    logic [31:0] next_addr;
    int          cyc, last_due;
    bit          after_rst;
    logic [31:0] m_fetched, m_flushed, m_stall;

    int p_ready, p_oready, p_rsp, p_redir, p_bogus, lat_min, lat_max;
    int n_assert = 0;
    int n_fail   = 0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return ~a ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit force_redir, input logic [31:0] rpc);
        bit          rsp, acc, deq, exp_rv;
        int          fresh, lat, due;
        logic [31:0] head, head4;
        req_t        p;

        @(negedge clk);
        rst            = r;
        imem_req_ready = ($urandom_range(99) < p_ready);
        out_ready      = ($urandom_range(99) < p_oready);
        redirect_valid = !r && (force_redir || ($urandom_range(99) < p_redir));
        if (force_redir)                   redirect_pc = rpc;
        else if ($urandom_range(3) == 0)   redirect_pc = 32'hFFFF_FFF0 | $urandom_range(15);
        else                               redirect_pc = $urandom;
        rsp = !r && pend.size() > 0 && pend[0].due <= cyc && ($urandom_range(99) < p_rsp);
        imem_rsp_valid = rsp || (!r && pend.size() == 0 && ($urandom_range(99) < p_bogus));
        imem_rsp_data  = rsp ? word_of(pend[0].addr) : $urandom;
        #1;

        exp_rv = !r && (pend.size() + q.size() < DEPTH) && !redirect_valid;
        chk("req_valid", imem_req_valid, exp_rv);
        if (!r || after_rst) chk("req_addr", imem_req_addr, next_addr);
        chk("out_valid", out_valid, q.size() != 0);
        if (q.size() != 0) begin
            head  = q[0];
            head4 = head + 32'd4;
            chk("out_pc", out_pc, head);
            chk("out_instr", out_instr, word_of(head));
            chk("out_pc4", out_pc4, head4);
        end else if (after_rst) begin
            chk("rst_out_instr", out_instr, 32'd0);
            chk("rst_out_pc", out_pc, 32'd0);
            chk("rst_out_pc4", out_pc4, 32'd4);
        end
`ifdef FQ_PERF_CNT_EN
        chk("perf_fetched", perf_fetched, m_fetched);
        chk("perf_flushed", perf_flushed, m_flushed);
        chk("perf_stall", perf_stall, m_stall);
`else
        chk("perf_tied", {perf_fetched, perf_flushed | perf_stall}, 64'd0);
`endif

        if (r) begin
            pend.delete();
            q.delete();
            next_addr = RESET_PC;
            last_due  = 0;
            m_fetched = 0; m_flushed = 0; m_stall = 0;
            after_rst = 1;
        end else begin
            after_rst = 0;
            acc = exp_rv && imem_req_ready;
            deq = q.size() != 0 && out_ready && !redirect_valid;
            if (q.size() != 0 && !out_ready) m_stall++;
            if (redirect_valid) begin
                fresh = 0;
                foreach (pend[i]) if (!pend[i].stale) fresh++;
                m_flushed += q.size() + fresh;
                q.delete();
                if (rsp) void'(pend.pop_front());
                foreach (pend[i]) pend[i].stale = 1;
                next_addr = redirect_pc & ~32'd3;
            end else begin
                if (deq) void'(q.pop_front());
                if (rsp) begin
                    p = pend.pop_front();
                    if (!p.stale) begin
                        q.push_back(p.addr);
                        m_fetched++;
                    end
                end
            end
            if (acc) begin
                lat = $urandom_range(lat_max, lat_min);
                due = cyc + lat;
                if (due < last_due) due = last_due;
                last_due = due;
                pend.push_back('{addr: next_addr, stale: 1'b0, due: due});
                next_addr = next_addr + 32'd4;
            end
        end
        cyc++;
    endtask

    task automatic knobs(input int rdy, input int ordy, input int rsp, input int redir,
                         input int bogus, input int lmin, input int lmax);
        p_ready = rdy; p_oready = ordy; p_rsp = rsp; p_redir = redir;
        p_bogus = bogus; lat_min = lmin; lat_max = lmax;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        cyc = 0; last_due = 0; after_rst = 0;
        next_addr = RESET_PC;
        m_fetched = 0; m_flushed = 0; m_stall = 0;

        // Reset, then a 1-cycle memory streaming sequentially
        knobs(100, 100, 100, 0, 0, 1, 1);
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        run(30);

        // Consumer stalled: credit must cap outstanding work at DEPTH
        knobs(100, 0, 100, 0, 0, 1, 1);
        run(10);
        knobs(100, 100, 100, 0, 0, 1, 1);
        run(20);

        // 3-cycle memory, redirect to a misaligned target
        knobs(100, 50, 100, 0, 0, 3, 3);
        run(8);
        step(1'b0, 1'b1, 32'h0000_1002);
        run(20);

        // Redirect while a response and a dequeue are both active
        knobs(100, 100, 100, 0, 0, 1, 1);
        run(10);
        step(1'b0, 1'b1, 32'h0000_2000);
        step(1'b0, 1'b1, 32'h0000_3004);
        run(10);

        // PC wrap at the top of the address space
        step(1'b0, 1'b1, 32'hFFFF_FFF4);
        run(15);

        // Mixed random traffic with protocol-error responses
        knobs(70, 60, 80, 5, 20, 1, 4);
        run(3000);

        // Reset with work queued and in flight
        knobs(100, 0, 100, 0, 0, 2, 3);
        run(6);
        step(1'b1, 1'b0, 32'd0);
        knobs(80, 70, 90, 3, 10, 1, 3);
        run(500);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
